// File: rtl/matcop_pkg.sv
// rtl/matcop_pkg.sv - shared sizes, FSM state type and element packing helper
package matcop_pkg;
  localparam int N_MAX  = 5;
  localparam int ELEM_W = 8;
  localparam int MAT_W  = N_MAX * N_MAX * ELEM_W;
  localparam int VEC_W  = N_MAX * ELEM_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Element (0,0) lives in the MSB byte; row-major packing.
  function automatic int elem_ofs(input int r, input int c);
    return MAT_W - 1 - ELEM_W * (N_MAX * r + c);
  endfunction
endpackage

// File: rtl/mat_vec_sel.sv
// rtl/mat_vec_sel.sv - picks row idx (or column idx) of a packed matrix, zeroing lanes >= n
module mat_vec_sel
  import matcop_pkg::*;
#(
  parameter bit COL_MODE = 1'b0
) (
  input  logic [MAT_W-1:0] mat,
  input  logic [2:0]       idx,
  input  logic [2:0]       n,
  output logic [VEC_W-1:0] vec
);

  always_comb begin
    vec = '0;
    for (int k = 0; k < N_MAX; k++) begin
      if ((3'(k) < n) && (int'(idx) < N_MAX)) begin
        if (COL_MODE)
          vec[VEC_W-1-ELEM_W*k -: ELEM_W] = mat[elem_ofs(k, int'(idx)) -: ELEM_W];
        else
          vec[VEC_W-1-ELEM_W*k -: ELEM_W] = mat[elem_ofs(int'(idx), k) -: ELEM_W];
      end
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - walks C(i,j) over an n x n job, feeding intProd_M one row/column pair per cycle
module matmul_seq_ctrl
  import matcop_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       size,
  input  logic [MAT_W-1:0] mat_a,
  input  logic [MAT_W-1:0] mat_b,
  output logic [VEC_W-1:0] lin,
  output logic [VEC_W-1:0] col,
  input  logic [7:0]       prod,
  input  logic             prod_ovf,
  output logic [MAT_W-1:0] mat_c,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  state_t           state;
  logic [2:0]       i, j, n_r;
  logic [MAT_W-1:0] a_r, b_r;
  logic [2:0]       sel_n;
  logic [2:0]       last;
  logic             size_ok;

  assign size_ok = (size >= 3'd1) && (size <= 3'd5);
  assign last    = n_r - 3'd1;
  // Masking every lane outside RUN keeps lin/col at zero without extra muxing.
  assign sel_n   = (state == RUN) ? n_r : 3'd0;

  mat_vec_sel #(.COL_MODE(1'b0)) u_row (.mat(a_r), .idx(i), .n(sel_n), .vec(lin));
  mat_vec_sel #(.COL_MODE(1'b1)) u_col (.mat(b_r), .idx(j), .n(sel_n), .vec(col));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      n_r   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      mat_c <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (size_ok) begin
              a_r   <= mat_a;
              b_r   <= mat_b;
              n_r   <= size;
              mat_c <= '0;
              ovf   <= 1'b0;
              err   <= 1'b0;
              i     <= '0;
              j     <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        RUN: begin
          mat_c[elem_ofs(int'(i), int'(j)) -: ELEM_W] <= prod;
          ovf <= ovf | prod_ovf;
          if (j == last) begin
            j <= '0;
            if (i == last) begin
              i     <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              i <= i + 3'd1;
            end
          end else begin
            j <= j + 3'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - directed scoreboard bench for matmul_seq_ctrl with a behavioural inner-product unit
module tb_matmul_seq_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   size;
  logic [199:0] mat_a, mat_b;
  logic [39:0]  lin, col;
  logic [7:0]   prod;
  logic         prod_ovf;
  logic [199:0] mat_c;
  logic         busy, done, ovf, err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [199:0] c;
    logic         ovf;
    logic         err;
    int           dcyc;
    int           bcyc;
  } exp_t;

  exp_t         sbq[$];
  logic [199:0] last_c;
  logic         last_ovf;
  int           ip_sum;

  always #5 clk = ~clk;

  matmul_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .size(size),
    .mat_a(mat_a), .mat_b(mat_b), .lin(lin), .col(col),
    .prod(prod), .prod_ovf(prod_ovf), .mat_c(mat_c),
    .busy(busy), .done(done), .ovf(ovf), .err(err)
  );

  // Stand-in for intProd_M: wraps to 8 bits and flags results outside int8.
  always_comb begin
    ip_sum = 0;
    for (int k = 0; k < 5; k++)
      ip_sum = ip_sum + int'($signed(lin[39-8*k -: 8])) * int'($signed(col[39-8*k -: 8]));
    prod     = ip_sum[7:0];
    prod_ovf = (ip_sum > 127) || (ip_sum < -128);
  end

  function automatic logic [199:0] put_el(input logic [199:0] m, input int r, input int c, input logic [7:0] v);
    m[199-8*(5*r+c) -: 8] = v;
    return m;
  endfunction

  function automatic int get_el(input logic [199:0] m, input int r, input int c);
    return int'($signed(m[199-8*(5*r+c) -: 8]));
  endfunction

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input logic [2:0] sz, input logic [199:0] a,
                         input logic [199:0] b, input bit poke);
    exp_t        e;
    int          n, s, dcyc, bcnt, lane_bad;
    logic [39:0] lmask;
    bit          valid;
    valid = (sz >= 3'd1) && (sz <= 3'd5);
    n = int'(sz);
    lmask = '0;
    if (valid) begin
      e.c = '0; e.ovf = 1'b0; e.err = 1'b0;
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) begin
          s = 0;
          for (int k = 0; k < n; k++) s = s + get_el(a, r, k) * get_el(b, k, c);
          e.c = put_el(e.c, r, c, s[7:0]);
          if (s > 127 || s < -128) e.ovf = 1'b1;
        end
      e.dcyc = n * n + 1;
      e.bcyc = n * n;
      for (int k = n; k < 5; k++) lmask[39-8*k -: 8] = 8'hFF;
    end else begin
      e.c = last_c; e.ovf = last_ovf; e.err = 1'b1;
      e.dcyc = 1; e.bcyc = 0;
    end
    last_c = e.c;
    last_ovf = e.ovf;
    sbq.push_back(e);

    @(negedge clk);
    start = 1'b1; size = sz; mat_a = a; mat_b = b;
    @(negedge clk);
    start = 1'b0; mat_a = ~a; mat_b = ~b;
    dcyc = 0; bcnt = 0; lane_bad = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (busy) begin
        bcnt++;
        if (((lin & lmask) != '0) || ((col & lmask) != '0)) lane_bad++;
      end
      if (done) begin
        dcyc = cyc;
        break;
      end
      start = poke && (cyc == 5);
      @(negedge clk);
    end
    e = sbq.pop_front();
    chk({tag, " done_cycle"}, 200'(dcyc), 200'(e.dcyc));
    chk({tag, " busy_cycles"}, 200'(bcnt), 200'(e.bcyc));
    chk({tag, " masked_lanes"}, 200'(lane_bad), 200'(0));
    chk({tag, " mat_c"}, mat_c, e.c);
    chk({tag, " ovf"}, 200'(ovf), 200'(e.ovf));
    chk({tag, " err"}, 200'(err), 200'(e.err));
    chk({tag, " idle_vectors"}, {120'(0), lin, col}, 200'(0));
    start = poke;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_pulse"}, 200'(done), 200'(0));
    @(negedge clk);
    chk({tag, " start_ignored"}, 200'(busy), 200'(0));
  endtask

  logic [199:0] a, b, cx, all127, ident;
  int           bad;

  initial begin
    rst = 1'b1; start = 1'b0; size = 3'd0; mat_a = '0; mat_b = '0;
    last_c = '0; last_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset mat_c", mat_c, 200'(0));
    chk("reset flags", 200'({busy, done, ovf, err}), 200'(0));
    chk("reset vectors", {120'(0), lin, col}, 200'(0));

    // Single dot product in C(0,0).
    a = '0; b = '0;
    a = put_el(a, 0, 0, 8'd1); a = put_el(a, 0, 1, 8'd2); a = put_el(a, 0, 2, 8'd3);
    a = put_el(a, 0, 3, 8'd2); a = put_el(a, 0, 4, 8'd5);
    b = put_el(b, 0, 0, 8'd2); b = put_el(b, 1, 0, 8'd3); b = put_el(b, 2, 0, 8'd2);
    b = put_el(b, 3, 0, 8'd1); b = put_el(b, 4, 0, 8'd1);
    run_job("t1", 3'd5, a, b, 1'b0);
    chk("t1 c00_const", mat_c, put_el('0, 0, 0, 8'd21));

    a = '0; b = '0;
    a = put_el(a, 0, 0, 8'd1); a = put_el(a, 0, 1, 8'd2); a = put_el(a, 1, 0, 8'd3); a = put_el(a, 1, 1, 8'd4);
    b = put_el(b, 0, 0, 8'd5); b = put_el(b, 0, 1, 8'd6); b = put_el(b, 1, 0, 8'd7); b = put_el(b, 1, 1, 8'd8);
    run_job("t2", 3'd2, a, b, 1'b0);
    cx = put_el('0, 0, 0, 8'd19); cx = put_el(cx, 0, 1, 8'd22);
    cx = put_el(cx, 1, 0, 8'd43); cx = put_el(cx, 1, 1, 8'd50);
    chk("t2 c_const", mat_c, cx);

    a = '0; b = '0;
    for (int k = 0; k < 5; k++) a = put_el(a, 0, k, 8'hFF);
    b = put_el(b, 0, 0, 8'd2); b = put_el(b, 1, 0, 8'd3); b = put_el(b, 2, 0, 8'hFE);
    b = put_el(b, 3, 0, 8'd1); b = put_el(b, 4, 0, 8'hFE);
    run_job("t3", 3'd5, a, b, 1'b0);
    chk("t3 c00_const", mat_c, put_el('0, 0, 0, 8'hFE));

    all127 = {25{8'd127}};
    run_job("t4", 3'd5, all127, all127, 1'b0);
    repeat (3) @(negedge clk);
    chk("t4 ovf_sticky", 200'(ovf), 200'(1));

    ident = '0;
    for (int k = 0; k < 5; k++) ident = put_el(ident, k, k, 8'd1);
    run_job("ident", 3'd5, ident, ident, 1'b1);
    chk("ident c_const", mat_c, ident);

    // Abandon a job at RUN cycle 10.
    @(negedge clk);
    start = 1'b1; size = 3'd5; mat_a = all127; mat_b = all127;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort mat_c", mat_c, 200'(0));
    chk("abort flags", 200'({busy, done, ovf, err}), 200'(0));
    chk("abort vectors", {120'(0), lin, col}, 200'(0));
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (done || busy) bad++;
    end
    chk("abort no_done", 200'(bad), 200'(0));
    last_c = '0; last_ovf = 1'b0;

    a = '0; b = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = put_el(a, r, c, 8'($urandom_range(0, 255)));
        b = put_el(b, r, c, 8'($urandom_range(0, 255)));
      end
    run_job("rand3", 3'd3, a, b, 1'b0);
    run_job("bad0", 3'd0, all127, all127, 1'b0);
    run_job("bad7", 3'd7, all127, all127, 1'b0);
    run_job("one", 3'd1, put_el('0, 0, 0, 8'hF9), put_el('0, 0, 0, 8'd3), 1'b0);
    chk("one c00_const", mat_c, put_el('0, 0, 0, 8'hEB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
- Sequencer that computes C = A × B for square signed 8-bit matrices of runtime size 1..5.
- Drives the 5-lane inner-product unit intProd_M with one row of A and one column of B per cycle, and captures its 8-bit result into C.
- ORs the unit's ovf flag into a sticky overflow status.
- Sits between the HPS-facing register file (operands, start/status) and the shared intProd_M instance.

Parameters:
- N_MAX, 5, maximum matrix dimension and lane count of intProd_M (fixed by the datapath).
- ELEM_W, 8, element width in bits (signed two's complement).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; honoured only in IDLE.
- size  in  3  matrix dimension n; valid values are 1..5.
- mat_a  in  200  matrix A; element (r,c) at bits [199-8*(5r+c) -: 8], so (0,0) is the MSB byte.
- mat_b  in  200  matrix B; same packing as mat_a.
- lin  out  40  row vector to intProd_M; lane 0 in the MSB byte.
- col  out  40  column vector to intProd_M; lane 0 in the MSB byte.
- prod  in  8  signed inner-product result from intProd_M (combinational, same cycle).
- prod_ovf  in  1  overflow flag from intProd_M.
- mat_c  out  200  result matrix; same packing as mat_a.
- busy  out  1  high while a job is in progress (RUN).
- done  out  1  one-cycle pulse at the end of a job.
- ovf  out  1  sticky: any captured product overflowed in the last job.
- err  out  1  last start had an invalid size.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, i=j=0.
  - mat_c=0, ovf=0, err=0, busy=0, done=0, lin=col=0.
  - Applies mid-job too: the job is abandoned and no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE with start=1 and size in 1..5:
  - latch mat_a, mat_b and size into internal registers (later input changes are ignored);
  - clear mat_c, ovf, err; i=j=0; go to RUN.
- IDLE with start=1 and size in {0,6,7}:
  - set err=1; mat_c and ovf keep their previous values; go to DONE.
- RUN, each cycle:
  - lin = latched A row i, col = latched B column j.
  - Lanes k >= n are forced to 0 on both vectors.
  - At the clock edge: C(i,j) <= prod, ovf <= ovf | prod_ovf.
  - Advance: j++. If j == n-1, then j=0 and i++. If i == n-1 and j == n-1, go to DONE.
- RUN lasts exactly n² cycles. busy=1 throughout RUN only.
- DONE: done=1 for exactly one cycle, then go to IDLE. lin=col=0 in all states except RUN.
- Latency: start accepted at edge E0 → captures at edges E1..E(n²) → done high in the cycle after E(n²).
- For an invalid size: done high in the cycle after E0.
- C elements outside n×n stay 0.
- Outputs mat_c, ovf and err hold until the next accepted start or reset.
- start in RUN or DONE is ignored; it is not queued.
- No arithmetic is performed here. Products are taken as delivered; wrap and saturation policy belongs to intProd_M.

Decomposition:
- matcop_pkg holds:
  - N_MAX, ELEM_W, MAT_W=200, VEC_W=40;
  - state enum {IDLE, RUN, DONE};
  - function elem_ofs(r,c) returning the MSB bit index of element (r,c).
- One natural combinational sub-module: mat_vec_sel, which extracts row i or column j from a 200-bit matrix and applies the lane mask for n. It is instantiated twice (row mode for A, column mode for B).
- intProd_M is instantiated by the parent and connected through lin/col/prod/prod_ovf.

Test Plan:
- size=5, A row0=[1,2,3,2,5], B col0=[2,3,2,1,1], all else 0 → C(0,0)=21, rest 0; busy for 25 cycles; done in cycle 26 after start; ovf=0.
- size=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → C=[[19,22],[43,50]], other 21 elements 0; done 4 cycles after RUN entry; lanes 2..4 of lin/col observed 0.
- size=5, A row0=all -1, B col0=[2,3,-2,1,-2] → C(0,0)=-2 (8'hFE); ovf=0.
- size=5, A and B all 127 → ovf=1 after done, and it stays 1 until the next start; second job with A=I, B=I gives C=I and ovf=0.
- rst pulsed at RUN cycle 10 of a size-5 job → next cycle: state IDLE, mat_c=0, busy=0, no done pulse; a start 2 cycles later completes normally.
- size=0 start → err=1, done pulse 1 cycle later, mat_c unchanged; start asserted during RUN or DONE → ignored, job count unchanged.
